// File: rtl/cmds_exec.sv
`default_nettype none
// ============================================================================
// Module   : cmds_exec
// Purpose  : Fetches an 8-byte maintenance command from CDCB memory, validates
//            it and performs a write / set-bits / clear-bits register access.
// Revision : 1.0 - initial release
// ============================================================================
module cmds_exec #(
    parameter logic [7:0]  DO_CMD   = 8'h01,
    parameter logic [11:0] MIN_ADDR = 12'd56,
    parameter logic [7:0]  REG_NUM  = 8'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start_con,
    input  logic [11:0] im_base_addr,
    output logic        o_done_con,
    output logic        o_error_con,
    output logic [2:0]  om_err_code,
    output logic        o_busy,
    output logic [11:0] om_cdcb_addr,
    input  logic [7:0]  im_cdcb_dout,
    output logic        o_reg_wren,
    output logic        o_reg_rden,
    output logic [7:0]  om_reg_addr,
    output logic [15:0] om_reg_din,
    input  logic [15:0] im_reg_dout
);

    localparam logic [7:0] c_OP_WR  = 8'h10;
    localparam logic [7:0] c_OP_SET = 8'h11;
    localparam logic [7:0] c_OP_CLR = 8'h12;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_FETCH = 4'd1,
        S_DRAIN = 4'd2,
        S_CHECK = 4'd3,
        S_RD    = 4'd4,
        S_RDW   = 4'd5,
        S_WR    = 4'd6,
        S_DONE  = 4'd7,
        S_ERR   = 4'd8
    } state_t;

    state_t      r_state;
    logic [11:0] r_base;
    logic [3:0]  r_fcnt;
    logic [3:0]  r_ccnt;
    logic        r_v1;
    logic        r_v2;
    logic [7:0]  r_b [8];

    logic [7:0]  w_xor;
    logic [15:0] w_data;
    logic        w_subop_ok;
    logic [2:0]  w_chk_code;

    assign w_xor      = r_b[0] ^ r_b[1] ^ r_b[2] ^ r_b[3] ^ r_b[4] ^ r_b[5] ^ r_b[6] ^ r_b[7];
    assign w_data     = {r_b[3], r_b[4]};
    assign w_subop_ok = (r_b[1] == c_OP_WR) || (r_b[1] == c_OP_SET) || (r_b[1] == c_OP_CLR);

    // Zero means the command passed every check.
    always_comb begin
        w_chk_code = 3'd0;
        if (w_xor != 8'h00)
            w_chk_code = 3'd3;
        else if (r_b[0] != DO_CMD)
            w_chk_code = 3'd2;
        else if (!w_subop_ok)
            w_chk_code = 3'd4;
        else if (r_b[2] >= REG_NUM)
            w_chk_code = 3'd5;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_fcnt       <= '0;
            r_ccnt       <= '0;
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            for (int i = 0; i < 8; i++) r_b[i] <= '0;
            o_done_con   <= 1'b0;
            o_error_con  <= 1'b0;
            om_err_code  <= '0;
            o_busy       <= 1'b0;
            om_cdcb_addr <= '0;
            o_reg_wren   <= 1'b0;
            o_reg_rden   <= 1'b0;
            om_reg_addr  <= '0;
            om_reg_din   <= '0;
        end else begin
            // Two-stage tag pipeline matches the CDCB read latency.
            r_v1 <= (r_state == S_FETCH);
            r_v2 <= r_v1;
            if (r_v2 && !r_ccnt[3]) begin
                r_b[r_ccnt[2:0]] <= im_cdcb_dout;
                r_ccnt           <= r_ccnt + 4'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_start_con) begin
                        r_base      <= im_base_addr;
                        r_ccnt      <= '0;
                        o_busy      <= 1'b1;
                        om_err_code <= '0;
                        if (im_base_addr < MIN_ADDR) begin
                            r_state     <= S_ERR;
                            o_error_con <= 1'b1;
                            om_err_code <= 3'd1;
                        end else begin
                            r_state      <= S_FETCH;
                            om_cdcb_addr <= im_base_addr;
                            r_fcnt       <= 4'd1;
                        end
                    end
                end
                S_FETCH: begin
                    if (r_fcnt == 4'd8) begin
                        om_cdcb_addr <= '0;
                        r_state      <= S_DRAIN;
                    end else begin
                        om_cdcb_addr <= r_base + {8'd0, r_fcnt};
                        r_fcnt       <= r_fcnt + 4'd1;
                    end
                end
                S_DRAIN: begin
                    // Leave as the eighth byte is being written.
                    if ((r_v2 && r_ccnt == 4'd7) || r_ccnt[3])
                        r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (w_chk_code != 3'd0) begin
                        r_state     <= S_ERR;
                        o_error_con <= 1'b1;
                        om_err_code <= w_chk_code;
                    end else if (r_b[1] == c_OP_WR) begin
                        r_state     <= S_WR;
                        o_reg_wren  <= 1'b1;
                        om_reg_addr <= r_b[2];
                        om_reg_din  <= w_data;
                    end else begin
                        r_state     <= S_RD;
                        o_reg_rden  <= 1'b1;
                        om_reg_addr <= r_b[2];
                    end
                end
                S_RD: begin
                    o_reg_rden  <= 1'b0;
                    om_reg_addr <= '0;
                    r_state     <= S_RDW;
                end
                S_RDW: begin
                    r_state     <= S_WR;
                    o_reg_wren  <= 1'b1;
                    om_reg_addr <= r_b[2];
                    if (r_b[1] == c_OP_SET)
                        om_reg_din <= im_reg_dout | w_data;
                    else
                        om_reg_din <= im_reg_dout & ~w_data;
                end
                S_WR: begin
                    o_reg_wren  <= 1'b0;
                    om_reg_addr <= '0;
                    om_reg_din  <= '0;
                    o_done_con  <= 1'b1;
                    om_err_code <= '0;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    o_done_con <= 1'b0;
                    o_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                S_ERR: begin
                    o_error_con <= 1'b0;
                    o_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state      <= S_IDLE;
                    o_done_con   <= 1'b0;
                    o_error_con  <= 1'b0;
                    o_busy       <= 1'b0;
                    om_cdcb_addr <= '0;
                    o_reg_wren   <= 1'b0;
                    o_reg_rden   <= 1'b0;
                    om_reg_addr  <= '0;
                    om_reg_din   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmds_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmds_exec
// Purpose  : Directed scoreboard bench for cmds_exec with CDCB and register
//            file models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmds_exec;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] base = '0;
    logic        done, error, busy, wren, rden;
    logic [2:0]  err_code;
    logic [11:0] cdcb_addr;
    logic [7:0]  cdcb_dout = '0;
    logic [7:0]  d1 = '0;
    logic [7:0]  reg_addr;
    logic [15:0] reg_din;
    logic [15:0] reg_dout = '0;

    logic [7:0]  mem  [4096];
    logic [15:0] regs [256];

    typedef struct packed {logic is_err; logic [2:0] code;} resp_t;
    typedef struct packed {logic [7:0] a; logic [15:0] d;} wr_t;
    resp_t q_resp[$];
    wr_t   q_wr[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int rd_cnt = 0;

    always #5 clk = ~clk;

    cmds_exec dut (
        .clk          (clk),
        .rst          (rst),
        .i_start_con  (start),
        .im_base_addr (base),
        .o_done_con   (done),
        .o_error_con  (error),
        .om_err_code  (err_code),
        .o_busy       (busy),
        .om_cdcb_addr (cdcb_addr),
        .im_cdcb_dout (cdcb_dout),
        .o_reg_wren   (wren),
        .o_reg_rden   (rden),
        .om_reg_addr  (reg_addr),
        .om_reg_din   (reg_din),
        .im_reg_dout  (reg_dout)
    );

    // Two-cycle CDCB read and one-cycle register read models.
    always @(posedge clk) begin
        d1        <= mem[cdcb_addr];
        cdcb_dout <= d1;
        if (rden) reg_dout <= regs[reg_addr];
    end

    // Monitor: compares every pulse and write strobe against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (cdcb_addr != 12'd0) rd_cnt++;
            if (done && error) begin
                n_cmp++; n_fail++;
                $display("FAIL both_pulses: done=%0b error=%0b, required never both", done, error);
            end else if (done || error) begin
                n_cmp++;
                if (q_resp.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: done=%0b error=%0b code=%0d, required none", done, error, err_code);
                end else begin
                    resp_t e;
                    e = q_resp.pop_front();
                    if (e.is_err != error || e.code != err_code) begin
                        n_fail++;
                        $display("FAIL response: error=%0b code=%0d, required error=%0b code=%0d", error, err_code, e.is_err, e.code);
                    end
                end
            end
            if (wren) begin
                n_cmp++;
                if (q_wr.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_wren: addr=%h din=%h, required no write", reg_addr, reg_din);
                end else begin
                    wr_t w;
                    w = q_wr.pop_front();
                    if (w.a != reg_addr || w.d != reg_din) begin
                        n_fail++;
                        $display("FAIL reg_write: addr=%h din=%h, required addr=%h din=%h", reg_addr, reg_din, w.a, w.d);
                    end
                end
            end
        end
    end

    function automatic logic [63:0] mk(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, input bit bad);
        logic [7:0] c;
        c = b0 ^ b1 ^ b2 ^ b3 ^ b4 ^ b5 ^ b6 ^ (bad ? 8'h5A : 8'h00);
        return {b0, b1, b2, b3, b4, b5, b6, c};
    endfunction

    task automatic load(input logic [11:0] b, input logic [63:0] cmd);
        for (int i = 0; i < 8; i++) mem[12'(b + 12'(i))] = cmd[63 - 8*i -: 8];
    endtask

    task automatic check_idle_outputs(input string nm);
        n_cmp++;
        if ({done, error, busy, wren, rden} != 5'd0 || cdcb_addr != 0 || reg_addr != 0 ||
            reg_din != 0 || err_code != 0) begin
            n_fail++;
            $display("FAIL %s: flags=%b cdcb=%h raddr=%h din=%h code=%0d, required all zero",
                     nm, {done, error, busy, wren, rden}, cdcb_addr, reg_addr, reg_din, err_code);
        end
    endtask

    task automatic run_cmd(input string nm, input logic [11:0] b, input logic [63:0] cmd,
                           input bit exp_err, input logic [2:0] code, input bit exp_wr,
                           input logic [7:0] wa, input logic [15:0] wd,
                           input int exp_reads, input int max_lat, input bit dbl);
        resp_t e;
        wr_t   w;
        int    lat;
        int    rd0;
        bit    seen;
        load(b, cmd);
        e.is_err = exp_err; e.code = code;
        q_resp.push_back(e);
        if (exp_wr) begin
            w.a = wa; w.d = wd;
            q_wr.push_back(w);
        end
        rd0 = rd_cnt;
        @(posedge clk); #1 start = 1'b1; base = b;
        @(posedge clk); #1 start = 1'b0; base = '0;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (dbl && lat == 3) begin start = 1'b1; base = 12'd40; end
            else if (dbl && lat == 4) start = 1'b0;
            if (done || error) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || lat > max_lat) begin
            n_fail++;
            $display("FAIL %s_latency: seen=%0b cycles=%0d, required pulse within %0d", nm, seen, lat, max_lat);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (rd_cnt - rd0 != exp_reads) begin
            n_fail++;
            $display("FAIL %s_reads: %0d nonzero CDCB addresses, required %0d", nm, rd_cnt - rd0, exp_reads);
        end
    endtask

    initial begin
        int  k;
        bit  got;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) regs[i] = 16'hDEAD;
        regs[7] = 16'h00F0;
        regs[9] = 16'h5A5A;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset_state");
        @(posedge clk); #1 rst = 1'b0;

        run_cmd("write",     12'd56,  mk(8'h01, 8'h10, 8'h05, 8'hAB, 8'hCD, 8'h00, 8'h00, 0), 0, 3'd0, 1, 8'h05, 16'hABCD, 8, 16, 0);
        run_cmd("set_bits",  12'd100, mk(8'h01, 8'h11, 8'h07, 8'h0F, 8'h00, 8'h00, 8'h00, 0), 0, 3'd0, 1, 8'h07, 16'h0FF0, 8, 16, 0);
        run_cmd("clr_bits",  12'd300, mk(8'h01, 8'h12, 8'h07, 8'h00, 8'h30, 8'h00, 8'h00, 0), 0, 3'd0, 1, 8'h07, 16'h00C0, 8, 16, 0);
        run_cmd("set_bits9", 12'd320, mk(8'h01, 8'h11, 8'h09, 8'h01, 8'h01, 8'h77, 8'h88, 0), 0, 3'd0, 1, 8'h09, 16'h5B5B, 8, 16, 0);
        run_cmd("cks_and_op",12'd400, mk(8'h02, 8'h10, 8'h05, 8'hAB, 8'hCD, 8'h00, 8'h00, 1), 1, 3'd3, 0, 8'h00, 16'h0000, 8, 16, 0);
        run_cmd("bad_op",    12'd420, mk(8'h02, 8'h10, 8'h05, 8'hAB, 8'hCD, 8'h00, 8'h00, 0), 1, 3'd2, 0, 8'h00, 16'h0000, 8, 16, 0);
        run_cmd("low_base",  12'd40,  mk(8'h01, 8'h10, 8'h05, 8'hAB, 8'hCD, 8'h00, 8'h00, 0), 1, 3'd1, 0, 8'h00, 16'h0000, 0, 2, 0);
        run_cmd("base_55",   12'd55,  mk(8'h01, 8'h10, 8'h05, 8'hAB, 8'hCD, 8'h00, 8'h00, 0), 1, 3'd1, 0, 8'h00, 16'h0000, 0, 2, 0);
        run_cmd("reg_40",    12'd440, mk(8'h01, 8'h10, 8'h40, 8'h12, 8'h34, 8'h00, 8'h00, 0), 1, 3'd5, 0, 8'h00, 16'h0000, 8, 16, 0);
        run_cmd("subop_33",  12'd460, mk(8'h01, 8'h33, 8'h05, 8'h12, 8'h34, 8'h00, 8'h00, 0), 1, 3'd4, 0, 8'h00, 16'h0000, 8, 16, 0);
        run_cmd("reg_3f",    12'd480, mk(8'h01, 8'h10, 8'h3F, 8'hFF, 8'hFF, 8'h00, 8'h00, 0), 0, 3'd0, 1, 8'h3F, 16'hFFFF, 8, 16, 0);
        run_cmd("double_st", 12'd500, mk(8'h01, 8'h10, 8'h0A, 8'h12, 8'h34, 8'h00, 8'h00, 0), 0, 3'd0, 1, 8'h0A, 16'h1234, 8, 16, 1);
        // Address wrap: FFC..003 contains one zero address, so 7 nonzero reads.
        run_cmd("addr_wrap", 12'hFFC, mk(8'h01, 8'h10, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 0), 0, 3'd0, 1, 8'h02, 16'h0001, 7, 16, 0);

        // Reset during RDW: nothing may be written or pulsed.
        load(12'd700, mk(8'h01, 8'h11, 8'h07, 8'h0F, 8'h00, 8'h00, 8'h00, 0));
        @(posedge clk); #1 start = 1'b1; base = 12'd700;
        @(posedge clk); #1 start = 1'b0; base = '0;
        k = 0; got = 1'b0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (rden) got = 1'b1;
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL rst_rden_seen: rden=0 after %0d cycles, required rden within 20", k);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("rst_in_rdw");
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        check_idle_outputs("post_rst_idle");

        run_cmd("after_rst", 12'd800, mk(8'h01, 8'h10, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 0), 0, 3'd0, 1, 8'h11, 16'h2233, 8, 16, 0);

        repeat (10) @(negedge clk);
        n_cmp++;
        if (q_resp.size() != 0 || q_wr.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d responses and %0d writes outstanding, required 0 and 0",
                     q_resp.size(), q_wr.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmds_exec.md
CMDS_EXEC -- requirements
Module: cmds_exec

Interface
REQ-001 Parameters SHALL be:
- DO_CMD, 8'h01, required opcode byte.
- MIN_ADDR, 12'd56, lowest legal maintenance command base address.
- REG_NUM, 8'd64, number of maintenance registers.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  single clock.
- rst  in  1  synchronous active-high reset.
- i_start_con  in  1  one-cycle request from the command scanner.
- im_base_addr  in  12  CDCB base address of the 8-byte command.
- o_done_con  out  1  one-cycle success pulse.
- o_error_con  out  1  one-cycle failure pulse.
- om_err_code  out  3  failure cause, held until the next accepted start.
- o_busy  out  1  high from the cycle after start acceptance until the cycle of the done/error pulse, inclusive; the top-level muxes the CDCB address on it.
- om_cdcb_addr  out  12  CDCB read address (2-cycle read latency).
- im_cdcb_dout  in  8  CDCB read data.
- o_reg_wren  out  1  maintenance register write strobe.
- o_reg_rden  out  1  maintenance register read strobe.
- om_reg_addr  out  8  register address.
- om_reg_din  out  16  register write data.
- im_reg_dout  in  16  register read data, valid 1 cycle after o_reg_rden.

Function
REQ-003 Command format SHALL be:
- B0 = opcode.
- B1 = sub-op: 0x10 write, 0x11 set-bits, 0x12 clear-bits.
- B2 = register address.
- B3:B4 = data, with B3 the MSB.
- B5, B6 = reserved.
- B7 = checksum, such that the XOR of B0..B7 is 8'h00.
REQ-004 States SHALL be IDLE, FETCH, DRAIN, CHECK, RD, RDW, WR, DONE, ERR; all other encodings SHALL return to IDLE.
REQ-005 IDLE: i_start_con=1 SHALL latch im_base_addr. If im_base_addr < MIN_ADDR, the next state SHALL be ERR with code 3'd1; otherwise the next state SHALL be FETCH, with om_cdcb_addr=im_base_addr.
REQ-006 FETCH SHALL present addresses base..base+7 on 8 consecutive cycles, incrementing by 1 modulo 2^12.
REQ-007 Each byte SHALL be captured exactly 2 cycles after its address was presented.
REQ-008 DRAIN SHALL hold until all 8 bytes are captured, then go to CHECK.
REQ-009 CHECK SHALL test, in this priority:
- checksum fail -> code 3'd3.
- B0 != DO_CMD -> code 3'd2.
- sub-op not 0x10/0x11/0x12 -> code 3'd4.
- B2 >= REG_NUM -> code 3'd5.
Any failure SHALL go to ERR.
REQ-010 On a passing CHECK, sub-op 0x10 SHALL go to WR; sub-ops 0x11 and 0x12 SHALL go to RD.
REQ-011 RD SHALL pulse o_reg_rden for one cycle with om_reg_addr=B2. RDW SHALL then capture im_reg_dout one cycle after that pulse.
REQ-012 WR SHALL pulse o_reg_wren for exactly one cycle with om_reg_addr=B2. om_reg_din SHALL be:
- 0x10: {B3,B4}.
- 0x11: captured | {B3,B4}.
- 0x12: captured & ~{B3,B4}.
REQ-013 DONE SHALL pulse o_done_con for one cycle, set om_err_code=0, and return to IDLE.
REQ-014 ERR SHALL pulse o_error_con for one cycle, drive om_err_code, and return to IDLE; o_reg_wren SHALL never assert on any error path.
REQ-015 o_done_con and o_error_con SHALL never be high in the same cycle, and exactly one SHALL pulse per accepted start.
REQ-016 Start-to-pulse latency SHALL be at most 16 cycles, well inside the scanner's 1000-cycle timeout.
REQ-017 i_start_con asserted while not in IDLE SHALL be ignored and SHALL NOT alter the latched address or the captured bytes.
REQ-018 om_cdcb_addr, om_reg_addr and om_reg_din SHALL be 0 whenever their respective strobes or o_busy are inactive.

Reset
REQ-019 rst=1 SHALL force, on the next clock edge: state IDLE, all outputs 0, om_err_code=0, captured bytes cleared.
REQ-020 Reset asserted mid-operation (any state before WR) SHALL produce no register write and no done/error pulse.
REQ-021 After rst deasserts, the first i_start_con SHALL be accepted in the following cycle.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Write: base=56, bytes 01 10 05 AB CD 00 00 checksum -> one wren, addr 0x05, din 0xABCD; done pulse within 16 cycles; code 0.
- Set-bits: reg 0x07 holds 0x00F0, cmd 01 11 07 0F 00 .. -> rden, then wren with din 0x0FF0; done.
- Bad checksum, also bad opcode 0x02 -> error, code 3 (checksum priority); no wren. Bad opcode alone, good checksum -> code 2.
- base=12'd40 -> error within 2 cycles, code 1; zero CDCB reads.
- Reg addr 0x40 -> code 5. Sub-op 0x33 -> code 4. Second i_start_con during FETCH ignored -> exactly one pulse.
- rst asserted during RDW -> no wren, no pulse, all outputs 0; a subsequent valid command completes normally.
